// File: rtl/prt_dp_lb_bridge.sv
// prt_dp_lb_bridge: CPU data port to P_PORTS local-bus slaves, one
// transaction at a time, single ACK for reads and writes, error ACK on
// decode miss (and on read timeout when PRT_LB_BRIDGE_TIMEOUT_EN is defined).
//
// Ports:
//   CLK_IN, RST_IN (async, active-low)
//   CPU_ADR_IN/CPU_DAT_IN/CPU_WR_IN/CPU_REQ_IN   : CPU request
//   CPU_DAT_OUT/CPU_ACK_OUT/CPU_ERR_OUT          : CPU response
//   LB_ADR_OUT/LB_DAT_OUT                        : shared downstream addr/data
//   LB_WR_OUT/LB_RD_OUT                          : one-hot strobes per port
//   LB_DAT_IN/LB_VLD_IN                          : per-port read return
//   ERR_CNT_OUT                                  : saturating error-ACK count
module prt_dp_lb_bridge #(
    parameter int P_PORTS   = 8,
    parameter int P_UP_ADR  = 22,
    parameter int P_DWN_ADR = 16,
    parameter int P_TIMEOUT = 255
) (
    input  logic                   CLK_IN,
    input  logic                   RST_IN,
    input  logic [P_UP_ADR-1:0]    CPU_ADR_IN,
    input  logic [31:0]            CPU_DAT_IN,
    input  logic                   CPU_WR_IN,
    input  logic                   CPU_REQ_IN,
    output logic [31:0]            CPU_DAT_OUT,
    output logic                   CPU_ACK_OUT,
    output logic                   CPU_ERR_OUT,
    output logic [P_DWN_ADR-1:0]   LB_ADR_OUT,
    output logic [31:0]            LB_DAT_OUT,
    output logic [P_PORTS-1:0]     LB_WR_OUT,
    output logic [P_PORTS-1:0]     LB_RD_OUT,
    input  logic [32*P_PORTS-1:0]  LB_DAT_IN,
    input  logic [P_PORTS-1:0]     LB_VLD_IN,
    output logic [7:0]             ERR_CNT_OUT
);

    localparam int LP_SW = (P_PORTS > 1) ? $clog2(P_PORTS) : 1;
    localparam logic [LP_SW:0] LP_NPORTS = (LP_SW+1)'(P_PORTS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RD_WAIT,
        S_ACK
    } state_t;

    state_t               r_state;
    logic                 r_dir;
    logic [P_PORTS-1:0]   r_hot;
    logic [31:0]          r_cpu_dat;
    logic                 r_ack;
    logic                 r_err;
    logic [P_DWN_ADR-1:0] r_lb_adr;
    logic [31:0]          r_lb_dat;
    logic [P_PORTS-1:0]   r_wr;
    logic [P_PORTS-1:0]   r_rd;
    logic [7:0]           r_err_cnt;

    logic [LP_SW-1:0]     w_sel;
    logic                 w_sel_ok;
    logic [P_PORTS-1:0]   w_hot;
    logic                 w_vld;
    logic [31:0]          w_rdat;
    logic [7:0]           w_cnt_inc;

    assign w_sel     = CPU_ADR_IN[P_DWN_ADR +: LP_SW];
    assign w_sel_ok  = ({1'b0, w_sel} < LP_NPORTS);
    assign w_hot     = P_PORTS'(1) << w_sel;
    // only the selected port's valid/data matter; others are masked out
    assign w_vld     = |(LB_VLD_IN & r_hot);
    assign w_cnt_inc = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;

    always_comb begin
        w_rdat = '0;
        for (int i = 0; i < P_PORTS; i++) begin
            if (r_hot[i]) begin
                w_rdat = LB_DAT_IN[32*i +: 32];
            end
        end
    end

    // address bits above the port select are not decoded
    generate
        if (P_UP_ADR > P_DWN_ADR + LP_SW) begin : g_hi_adr
            logic w_unused_adr;
            assign w_unused_adr = ^CPU_ADR_IN[P_UP_ADR-1:P_DWN_ADR+LP_SW];
        end
    endgenerate

`ifdef PRT_LB_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] LP_TO_LAST = 16'(P_TIMEOUT - 1);
    logic [15:0] r_to_cnt;
`else
    logic [15:0] w_unused_to;
    assign w_unused_to = 16'(P_TIMEOUT);
`endif

    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            r_state   <= S_IDLE;
            r_dir     <= 1'b0;
            r_hot     <= '0;
            r_cpu_dat <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_lb_adr  <= '0;
            r_lb_dat  <= '0;
            r_wr      <= '0;
            r_rd      <= '0;
            r_err_cnt <= '0;
`ifdef PRT_LB_BRIDGE_TIMEOUT_EN
            r_to_cnt  <= '0;
`endif
        end else begin
            r_ack <= 1'b0;
            r_wr  <= '0;
            r_rd  <= '0;
            unique case (r_state)
                S_IDLE: begin
                    if (CPU_REQ_IN) begin
                        r_dir <= CPU_WR_IN;
                        if (w_sel_ok) begin
                            r_hot    <= w_hot;
                            r_lb_adr <= CPU_ADR_IN[P_DWN_ADR-1:0];
                            r_lb_dat <= CPU_DAT_IN;
                            if (CPU_WR_IN) begin
                                r_wr <= w_hot;
                            end else begin
                                r_rd <= w_hot;
                            end
                            r_state <= S_ISSUE;
                        end else begin
                            // no such port: answer at once, never strobe
                            r_ack     <= 1'b1;
                            r_err     <= 1'b1;
                            r_err_cnt <= w_cnt_inc;
                            if (!CPU_WR_IN) begin
                                r_cpu_dat <= 32'hFFFF_FFFF;
                            end
                            r_state <= S_ACK;
                        end
                    end
                end
                S_ISSUE: begin
                    if (r_dir) begin
                        r_ack   <= 1'b1;
                        r_err   <= 1'b0;
                        r_state <= S_ACK;
                    end else begin
`ifdef PRT_LB_BRIDGE_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                        r_state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    // valid is checked first so it beats a same-cycle expiry
                    if (w_vld) begin
                        r_ack     <= 1'b1;
                        r_err     <= 1'b0;
                        r_cpu_dat <= w_rdat;
                        r_state   <= S_ACK;
                    end
`ifdef PRT_LB_BRIDGE_TIMEOUT_EN
                    else if (r_to_cnt == LP_TO_LAST) begin
                        r_ack     <= 1'b1;
                        r_err     <= 1'b1;
                        r_err_cnt <= w_cnt_inc;
                        r_cpu_dat <= 32'hFFFF_FFFF;
                        r_state   <= S_ACK;
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
`endif
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign CPU_DAT_OUT = r_cpu_dat;
    assign CPU_ACK_OUT = r_ack;
    assign CPU_ERR_OUT = r_err;
    assign LB_ADR_OUT  = r_lb_adr;
    assign LB_DAT_OUT  = r_lb_dat;
    assign LB_WR_OUT   = r_wr;
    assign LB_RD_OUT   = r_rd;
    assign ERR_CNT_OUT = r_err_cnt;

endmodule
